// File: rtl/equihash_uart_tx.sv
// Result-word serializer: a small FIFO of 65-bit entries (word or frame
// marker) drained by an 8N1 UART transmitter, low byte of each word first.
module equihash_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 4
) (
   input  logic        eclk,
   input  logic        rstb,
   input  logic        uart_start,
   input  logic [63:0] uart_tdata,
   input  logic        uart_headernonce_send,
   output logic        uart_txd,
   output logic        tx_busy,
   output logic        fifo_full,
   output logic        overflow_err
);

   localparam int                DEPTH     = 1 << FIFO_AW;
   localparam int                BAUD_W    = 12;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [7:0]        MARKER    = 8'h5A;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [FIFO_AW:0]    r_wr_ptr;
   logic [FIFO_AW:0]    r_rd_ptr;
   logic [64:0]         r_mem [DEPTH];
   logic [63:0]         r_entry_data;
   logic                r_entry_marker;
   logic [3:0]          r_bytes_left;
   logic [7:0]          r_shift;
   logic [2:0]          r_bit_cnt;
   logic [BAUD_W-1:0]   r_baud_cnt;
   logic                r_txd;
   logic                r_overflow;
   logic                r_armed;

   logic                w_empty;
   logic                w_full;
   logic                w_baud_done;
   logic                w_pop;
   logic                w_strobe;
   logic                w_push;
   logic                w_drop;
   logic [64:0]         w_wdata;
   logic [64:0]         w_head;

   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                        (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
   assign w_baud_done = (r_baud_cnt == BAUD_LAST);
   assign w_head      = r_mem[r_rd_ptr[FIFO_AW-1:0]];

   // A marker wins over a simultaneous word; a pop in the same cycle frees a slot even when full.
   assign w_strobe = (uart_start | uart_headernonce_send) & r_armed;
   assign w_push   = w_strobe & (~w_full | w_pop);
   assign w_drop   = r_armed & ((uart_start & uart_headernonce_send) |
                                (w_strobe & w_full & ~w_pop));
   assign w_wdata  = uart_headernonce_send ? {1'b1, 64'h0} : {1'b0, uart_tdata};

   assign uart_txd     = r_txd;
   assign tx_busy      = (r_state != S_IDLE) | ~w_empty;
   assign fifo_full    = w_full;
   assign overflow_err = r_overflow;

   // State register.
   always_ff @(posedge eclk or negedge rstb) begin
      if (!rstb) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state and FIFO pop decode.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      w_next_state = r_state;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_next_state = S_LOAD;
            end
         end
         S_LOAD:  w_next_state = S_START;
         S_START: if (w_baud_done) w_next_state = S_DATA;
         S_DATA:  if (w_baud_done && r_bit_cnt == 3'd7) w_next_state = S_STOP;
         S_STOP: begin
            if (w_baud_done) begin
               if (r_bytes_left != 4'd0) begin
                  w_next_state = S_LOAD;
               end else if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_next_state = S_LOAD;
               end else begin
                  w_next_state = S_IDLE;
               end
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // FIFO storage.
   always_ff @(posedge eclk) begin
      // NOTE: the array has no reset; the pointers alone define which entries are valid.
      if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_wdata;
   end

   // FIFO pointers, sticky overflow flag and post-reset strobe qualifier.
   always_ff @(posedge eclk or negedge rstb) begin
      if (!rstb) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // Entry unpacking, bit timing and the registered serial line.
   always_ff @(posedge eclk or negedge rstb) begin
      if (!rstb) begin
         r_entry_data   <= '0;
         r_entry_marker <= 1'b0;
         r_bytes_left   <= '0;
         r_shift        <= '0;
         r_bit_cnt      <= '0;
         r_baud_cnt     <= '0;
         r_txd          <= 1'b1;
      end else begin
         case (r_state)
            S_LOAD: begin
               r_shift      <= r_entry_marker ? MARKER : r_entry_data[7:0];
               r_entry_data <= r_entry_data >> 8;
               r_bytes_left <= r_bytes_left - 4'd1;
               r_bit_cnt    <= '0;
               r_baud_cnt   <= '0;
            end
            S_START, S_STOP: begin
               r_baud_cnt <= w_baud_done ? '0 : r_baud_cnt + 1'b1;
            end
            S_DATA: begin
               r_baud_cnt <= w_baud_done ? '0 : r_baud_cnt + 1'b1;
               if (w_baud_done) begin
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end
            default: ;
         endcase
         if (w_pop) begin
            r_entry_data   <= w_head[63:0];
            r_entry_marker <= w_head[64];
            r_bytes_left   <= w_head[64] ? 4'd1 : 4'd8;
         end
         case (r_state)
            S_START: r_txd <= 1'b0;
            S_DATA:  r_txd <= r_shift[0];
            default: r_txd <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_equihash_uart_tx.sv
// Bench for equihash_uart_tx: expected serial bytes are queued at stimulus
// time and a mid-bit sampling UART receiver pops and compares them.
module tb_equihash_uart_tx;

   localparam int CPB  = 4;
   localparam int AW   = 2;
   localparam int HALF = CPB / 2;

   logic        eclk = 1'b0;
   logic        rstb = 1'b1;
   logic        uart_start = 1'b0;
   logic [63:0] uart_tdata = '0;
   logic        uart_headernonce_send = 1'b0;
   logic        uart_txd;
   logic        tx_busy;
   logic        fifo_full;
   logic        overflow_err;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [7:0]  exp_q [$];

   equihash_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .eclk                  (eclk),
      .rstb                  (rstb),
      .uart_start            (uart_start),
      .uart_tdata            (uart_tdata),
      .uart_headernonce_send (uart_headernonce_send),
      .uart_txd              (uart_txd),
      .tx_busy               (tx_busy),
      .fifo_full             (fifo_full),
      .overflow_err          (overflow_err)
   );

   always #5 eclk = ~eclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // Reference: a word is its eight bytes low first, a marker is one 0x5A byte.
   task automatic expect_entry(input logic marker, input logic [63:0] w);
      if (marker) exp_q.push_back(8'h5A);
      else for (int k = 0; k < 8; k++) exp_q.push_back(8'((w >> (8 * k)) & 64'hFF));
   endtask

   // Called at a falling edge; the strobe is seen by the next rising edge.
   task automatic strobe(input logic s, input logic h, input logic [63:0] d);
      uart_start            = s;
      uart_headernonce_send = h;
      uart_tdata            = d;
      @(negedge eclk);
      uart_start            = 1'b0;
      uart_headernonce_send = 1'b0;
      uart_tdata            = {$urandom, $urandom};
   endtask

   task automatic assert_reset_now();
      rstb = 1'b0;
      #1;
      check("rst_txd", uart_txd, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_full", fifo_full, 0);
      check("rst_ovf", overflow_err, 0);
      exp_q.delete();
      repeat (2) @(negedge eclk);
      @(posedge eclk);
      #2 rstb = 1'b1;
      repeat (2) @(negedge eclk);
   endtask

   task automatic do_reset();
      @(posedge eclk);
      #2;
      assert_reset_now();
   endtask

   task automatic wait_drained(input int limit);
      int n = 0;
      while ((tx_busy || exp_q.size() != 0) && n < limit) begin
         @(negedge eclk);
         n++;
      end
      check("drained", {63'b0, (tx_busy || exp_q.size() != 0)}, 0);
      repeat (2 * CPB) @(negedge eclk);
   endtask

   // Receiver: find a start bit, sample each bit near its middle, score the byte.
   initial begin : monitor
      bit         active = 1'b0;
      int         cnt    = 0;
      logic [7:0] b      = '0;
      forever begin
         @(negedge eclk);
         if (!rstb) begin
            active = 1'b0;
         end else if (!active) begin
            if (uart_txd === 1'b0) begin
               active = 1'b1;
               cnt    = 0;
            end
         end else begin
            cnt++;
            if (cnt == HALF) begin
               check("start_bit", uart_txd, 0);
            end else if (cnt == HALF + 9 * CPB) begin
               check("stop_bit", uart_txd, 1);
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_byte: got %02h, required none", b);
               end else begin
                  check("rx_byte", b, exp_q.pop_front());
               end
               active = 1'b0;
            end else if ((cnt - HALF) % CPB == 0) begin
               b[(cnt - HALF) / CPB - 1] = uart_txd;
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [63:0] w;
      logic [63:0] words [6];
      int          cycles;
      int          lows;

      do_reset();

      // Single word: start bit 3 cycles after push, 329 busy cycles in total.
      expect_entry(1'b0, 64'h0123456789ABCDEF);
      strobe(1'b1, 1'b0, 64'h0123456789ABCDEF);
      @(posedge eclk);
      @(posedge eclk);
      #1 check("txd_high_at_plus2", uart_txd, 1);
      @(posedge eclk);
      #1 check("txd_low_at_plus3", uart_txd, 0);
      cycles = 3;
      while (tx_busy && cycles < 2000) begin
         @(posedge eclk);
         #1 cycles++;
      end
      check("busy_cycles", cycles, 329);
      wait_drained(200);
      check("ovf_clear_word", overflow_err, 0);

      // Marker then word on the next cycle.
      expect_entry(1'b1, 64'h0);
      strobe(1'b0, 1'b1, {$urandom, $urandom});
      expect_entry(1'b0, 64'h1);
      strobe(1'b1, 1'b0, 64'h1);
      wait_drained(1000);
      check("ovf_clear_seq", overflow_err, 0);

      // Both strobes together: marker only, sticky overflow.
      expect_entry(1'b1, 64'h0);
      strobe(1'b1, 1'b1, 64'hFFFF_0000_AAAA_5555);
      check("ovf_both_strobes", overflow_err, 1);
      wait_drained(200);
      check("ovf_sticky", overflow_err, 1);

      // Full FIFO with a push landing on the pop edge.
      do_reset();
      for (int i = 0; i < 6; i++) words[i] = {$urandom, $urandom};
      for (int i = 0; i < 5; i++) begin
         expect_entry(1'b0, words[i]);
         strobe(1'b1, 1'b0, words[i]);
      end
      check("full_after_5", fifo_full, 1);
      check("ovf_after_5", overflow_err, 0);
      repeat (324) @(negedge eclk);
      check("full_before_pop", fifo_full, 1);
      expect_entry(1'b0, words[5]);
      strobe(1'b1, 1'b0, words[5]);
      check("full_after_pushpop", fifo_full, 1);
      check("ovf_after_pushpop", overflow_err, 0);
      wait_drained(3000);

      // Sixth push into a full FIFO is dropped.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         w = {$urandom, $urandom};
         expect_entry(1'b0, w);
         strobe(1'b1, 1'b0, w);
      end
      check("full_before_6th", fifo_full, 1);
      check("ovf_before_6th", overflow_err, 0);
      strobe(1'b1, 1'b0, {$urandom, $urandom});
      check("ovf_after_6th", overflow_err, 1);
      check("full_after_6th", fifo_full, 1);
      wait_drained(2500);

      // Reset during the third data bit of byte 0.
      do_reset();
      w = {$urandom, $urandom};
      expect_entry(1'b0, w);
      strobe(1'b1, 1'b0, w);
      repeat (16) @(posedge eclk);
      #2 check("txd_data_bit2", uart_txd, {63'b0, w[2]});
      assert_reset_now();
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge eclk);
         if (uart_txd !== 1'b1) lows++;
      end
      check("quiet_after_reset", lows, 0);
      check("idle_after_reset", tx_busy, 0);

      // Random bursts of words and markers with random spacing.
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int j = 0; j < n; j++) begin
            logic mk;
            mk = ($urandom_range(0, 3) == 0);
            w  = {$urandom, $urandom};
            expect_entry(mk, w);
            strobe(!mk, mk, w);
            repeat ($urandom_range(0, 3)) @(negedge eclk);
         end
         wait_drained(n * 400 + 100);
      end
      check("ovf_clear_random", overflow_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
